icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache that sits directly downstream of the fetch stage.
- Each cycle it consumes the fetch PC and request strobe and returns the instruction word toward the IF/ID register.
- On a miss it raises a stall request to the flow controller and refills the whole line from the instruction memory bus with a req/ack handshake.
- Tag and data storage are flop arrays; no write path.

---
 rtl/icache_dm_if.sv | 41 ++++
 rtl/icache_dm.sv | 159 +++++++++++++++
 tb/tb_icache_dm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The perf counter outputs exist only when ICACHE_PERF_CNT_EN is defined.
interface icache_dm_if;
    logic [31:0] if_pc_i;
    logic        if_req_i;
    logic        if_kill_i;
    logic        ic_flush_i;
    logic [31:0] ic_inst_o;
    logic        ic_inst_valid_o;
    logic        ic_stall_req_o;
    logic        ic_mem_req_o;
    logic [31:0] ic_mem_addr_o;
    logic [31:0] ic_mem_rdata_i;
    logic        ic_mem_ack_i;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] ic_hit_cnt_o;
    logic [31:0] ic_miss_cnt_o;
`endif

`ifdef ICACHE_PERF_CNT_EN
    modport slave (
        input  if_pc_i, if_req_i, if_kill_i, ic_flush_i, ic_mem_rdata_i, ic_mem_ack_i,
        output ic_inst_o, ic_inst_valid_o, ic_stall_req_o, ic_mem_req_o, ic_mem_addr_o,
        output ic_hit_cnt_o, ic_miss_cnt_o
    );
    modport master (
        output if_pc_i, if_req_i, if_kill_i, ic_flush_i, ic_mem_rdata_i, ic_mem_ack_i,
        input  ic_inst_o, ic_inst_valid_o, ic_stall_req_o, ic_mem_req_o, ic_mem_addr_o,
        input  ic_hit_cnt_o, ic_miss_cnt_o
    );
`else
    modport slave (
        input  if_pc_i, if_req_i, if_kill_i, ic_flush_i, ic_mem_rdata_i, ic_mem_ack_i,
        output ic_inst_o, ic_inst_valid_o, ic_stall_req_o, ic_mem_req_o, ic_mem_addr_o
    );
    modport master (
        output if_pc_i, if_req_i, if_kill_i, ic_flush_i, ic_mem_rdata_i, ic_mem_ack_i,
        input  ic_inst_o, ic_inst_valid_o, ic_stall_req_o, ic_mem_req_o, ic_mem_addr_o
    );
`endif
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill over a req/ack bus.
// Define ICACHE_PERF_CNT_EN to add hit/miss counters.
module icache_dm #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input logic        clk,
    input logic        rst_n,
    icache_dm_if.slave bus
);
    localparam int WB   = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(LINES);
    localparam int OFF  = WB + 2;
    localparam int TAGW = 32 - OFF - IDX;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_e;

    state_e            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [31:0]       data_q [LINES][LINE_WORDS];
    logic [31:2]       req_pc_q, req_pc_d;
    logic [WB-1:0]     beat_q, beat_d;
    logic              kill_pend_q, kill_pend_d;
    logic              flush_pend_q, flush_pend_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;

    logic [WB-1:0]     pc_word, rq_word;
    logic [IDX-1:0]    pc_idx, rq_idx;
    logic [TAGW-1:0]   pc_tag, rq_tag;
    logic              hit, last_beat, refill_wr;
    logic [1:0]        unused_pc;

    assign pc_word   = bus.if_pc_i[OFF-1:2];
    assign pc_idx    = bus.if_pc_i[OFF+IDX-1:OFF];
    assign pc_tag    = bus.if_pc_i[31:OFF+IDX];
    assign rq_word   = req_pc_q[OFF-1:2];
    assign rq_idx    = req_pc_q[OFF+IDX-1:OFF];
    assign rq_tag    = req_pc_q[31:OFF+IDX];
    assign unused_pc = bus.if_pc_i[1:0];

    // A same-cycle flush turns any lookup into a miss.
    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !bus.ic_flush_i;
    assign last_beat = (beat_q == WB'(LINE_WORDS - 1));
    assign refill_wr = (state_q == REFILL) && bus.ic_mem_ack_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            req_pc_q     <= '0;
            beat_q       <= '0;
            kill_pend_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            req_pc_q     <= req_pc_d;
            beat_q       <= beat_d;
            kill_pend_q  <= kill_pend_d;
            flush_pend_q <= flush_pend_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Payload arrays need no reset: nothing is read before its valid bit is set.
    always_ff @(posedge clk) begin
        if (refill_wr) begin
            data_q[rq_idx][beat_q] <= bus.ic_mem_rdata_i;
            if (last_beat) tag_q[rq_idx] <= rq_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.if_req_i && !hit) state_d = REFILL;
            REFILL:  if (refill_wr && last_beat) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        req_pc_d     = req_pc_q;
        beat_d       = beat_q;
        kill_pend_d  = kill_pend_q;
        flush_pend_d = flush_pend_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ic_flush_i) valid_d = '0;
                if (bus.if_req_i && hit) begin
                    inst_d       = data_q[pc_idx][pc_word];
                    inst_valid_d = !bus.if_kill_i;
                end else if (bus.if_req_i) begin
                    req_pc_d    = bus.if_pc_i[31:2];
                    beat_d      = '0;
                    kill_pend_d = 1'b0;
                end
            end
            REFILL: begin
                if (bus.if_kill_i)  kill_pend_d  = 1'b1;
                if (bus.ic_flush_i) flush_pend_d = 1'b1;
                if (refill_wr) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) valid_d[rq_idx] = 1'b1;
                end
            end
            RESP: begin
                // Response is delivered first; a pending flush lands on the way back to IDLE.
                inst_d       = data_q[rq_idx][rq_word];
                flush_pend_d = 1'b0;
                if (flush_pend_q || bus.ic_flush_i) valid_d = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.ic_stall_req_o  = (state_q == REFILL) || ((state_q == IDLE) && bus.if_req_i && !hit);
        bus.ic_mem_req_o    = (state_q == REFILL);
        bus.ic_mem_addr_o   = (state_q == REFILL) ? {req_pc_q[31:OFF], beat_q, 2'b00} : '0;
        bus.ic_inst_o       = (state_q == RESP) ? data_q[rq_idx][rq_word] : inst_q;
        bus.ic_inst_valid_o = (state_q == RESP) ? !kill_pend_q : inst_valid_q;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && bus.if_req_i) begin
            if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
            else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.ic_hit_cnt_o  = hit_cnt_q;
    assign bus.ic_miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios with literal expectations, then random
// traffic checked every cycle against a line-level model of cache contents.
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_dm_if ifc();
    icache_dm #(.LINES(16), .LINE_WORDS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    int          n_vec = 0;
    int          n_err = 0;
    int          gap = 1;
    int          wait_cnt = 0;
    bit          rand_gap = 1'b0;
    logic [31:0] addrq[$];

    // Backing memory: word at line L, offset w is ((L-1)<<8) + 0xA0 + w.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (((a >> 4) - 32'd1) << 8) + 32'hA0 + {30'd0, a[3:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive fetch inputs and the memory responder just after the edge.
    task automatic cyc(input logic req, input logic [31:0] pc, input logic kill, input logic flush);
        @(posedge clk); #1;
        ifc.if_req_i   = req;
        ifc.if_pc_i    = pc;
        ifc.if_kill_i  = kill;
        ifc.ic_flush_i = flush;
        if (ifc.ic_mem_req_o && wait_cnt >= gap) begin
            ifc.ic_mem_ack_i   = 1'b1;
            ifc.ic_mem_rdata_i = memw(ifc.ic_mem_addr_o);
            addrq.push_back(ifc.ic_mem_addr_o);
            wait_cnt = 0;
            if (rand_gap) gap = $urandom_range(0, 2);
        end else begin
            ifc.ic_mem_ack_i   = 1'b0;
            ifc.ic_mem_rdata_i = $urandom;
            wait_cnt = ifc.ic_mem_req_o ? wait_cnt + 1 : 0;
        end
    endtask

    // Idles fetch until the stall drops (the response cycle); optional kill/flush
    // are raised while the refill presents a given address.
    task automatic wait_resp(input logic [31:0] kill_at, input logic [31:0] flush_at);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1'b0, 32'd0, 1'b0, 1'b0); #2;
            if (!ifc.ic_stall_req_o) found = 1'b1;
            else begin
                if (ifc.ic_mem_addr_o == kill_at)  ifc.if_kill_i  = 1'b1;
                if (ifc.ic_mem_addr_o == flush_at) ifc.ic_flush_i = 1'b1;
            end
        end
        chk("resp_timeout", 32'(found), 32'd1);
    endtask

    task automatic check_addrs(input string nm, input logic [31:0] base);
        chk({nm, "_nbeats"}, 32'(addrq.size()), 32'd4);
        for (int i = 0; i < 4 && i < addrq.size(); i++)
            chk({nm, "_addr"}, addrq[i], base + 32'(4 * i));
    endtask

    // Reference model: which memory line each index holds, plus the outstanding request.
    int          m_line[16];
    bit          m_busy, m_resp, m_kill, m_flushp, m_expv, m_hit;
    logic [31:0] m_pc, m_expi;
    int          m_beat, m_idx, m_ln;

    task automatic clear_lines();
        for (int i = 0; i < 16; i++) m_line[i] = -1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid",  32'(ifc.ic_inst_valid_o), 32'd0);
            chk("rst_memreq", 32'(ifc.ic_mem_req_o),    32'd0);
            chk("rst_stall",  32'(ifc.ic_stall_req_o),  32'd0);
            chk("rst_addr",   ifc.ic_mem_addr_o,        32'd0);
            clear_lines();
            m_busy = 0; m_resp = 0; m_kill = 0; m_flushp = 0; m_expv = 0;
        end else if (m_resp) begin
            chk("m_resp_stall", 32'(ifc.ic_stall_req_o),  32'd0);
            chk("m_resp_req",   32'(ifc.ic_mem_req_o),    32'd0);
            chk("m_resp_valid", 32'(ifc.ic_inst_valid_o), 32'(!m_kill));
            chk("m_resp_inst",  ifc.ic_inst_o,            memw(m_pc));
            if (m_flushp || ifc.ic_flush_i) clear_lines();
            m_flushp = 0; m_resp = 0; m_expv = 0;
        end else if (m_busy) begin
            chk("m_fill_stall", 32'(ifc.ic_stall_req_o),  32'd1);
            chk("m_fill_req",   32'(ifc.ic_mem_req_o),    32'd1);
            chk("m_fill_addr",  ifc.ic_mem_addr_o,        {m_pc[31:4], 4'b0} + 32'(4 * m_beat));
            chk("m_fill_valid", 32'(ifc.ic_inst_valid_o), 32'd0);
            if (ifc.if_kill_i)  m_kill = 1;
            if (ifc.ic_flush_i) m_flushp = 1;
            if (ifc.ic_mem_ack_i) begin
                m_beat++;
                if (m_beat == 4) begin
                    m_line[int'(m_pc[7:4])] = int'(m_pc[31:4]);
                    m_busy = 0;
                    m_resp = 1;
                end
            end
        end else begin
            m_idx = int'(ifc.if_pc_i[7:4]);
            m_ln  = int'(ifc.if_pc_i[31:4]);
            m_hit = (m_line[m_idx] == m_ln) && !ifc.ic_flush_i;
            chk("m_idle_stall", 32'(ifc.ic_stall_req_o),  32'(ifc.if_req_i && !m_hit));
            chk("m_idle_req",   32'(ifc.ic_mem_req_o),    32'd0);
            chk("m_idle_valid", 32'(ifc.ic_inst_valid_o), 32'(m_expv));
            if (m_expv) chk("m_idle_inst", ifc.ic_inst_o, m_expi);
            m_expv = 0;
            if (ifc.if_req_i && m_hit) begin
                m_expv = !ifc.if_kill_i;
                m_expi = memw(ifc.if_pc_i);
            end else if (ifc.if_req_i) begin
                m_busy = 1; m_pc = ifc.if_pc_i; m_beat = 0; m_kill = 0;
            end
            if (ifc.ic_flush_i) clear_lines();
        end
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        ifc.if_req_i = 1'b0; ifc.if_pc_i = '0; ifc.if_kill_i = 1'b0; ifc.ic_flush_i = 1'b0;
        ifc.ic_mem_ack_i = 1'b0; ifc.ic_mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("reset_inst", ifc.ic_inst_o, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Cold miss
        addrq.delete();
        cyc(1'b1, 32'h10, 1'b0, 1'b0); #2;
        chk("cold_stall", 32'(ifc.ic_stall_req_o), 32'd1);
        wait_resp(NONE, NONE);
        chk("cold_inst",  ifc.ic_inst_o, 32'hA0);
        chk("cold_valid", 32'(ifc.ic_inst_valid_o), 32'd1);
        check_addrs("cold", 32'h10);

        // Hit, then hit killed by redirect
        cyc(1'b1, 32'h18, 1'b0, 1'b0); #2;
        chk("hit_stall", 32'(ifc.ic_stall_req_o), 32'd0);
        cyc(1'b1, 32'h18, 1'b1, 1'b0); #2;
        chk("hit_inst",   ifc.ic_inst_o, 32'hA2);
        chk("hit_valid",  32'(ifc.ic_inst_valid_o), 32'd1);
        chk("hit_memreq", 32'(ifc.ic_mem_req_o), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0); #2;
        chk("hitkill_valid", 32'(ifc.ic_inst_valid_o), 32'd0);

        // Conflict on index 1
        addrq.delete();
        cyc(1'b1, 32'h110, 1'b0, 1'b0); #2;
        chk("conf_stall", 32'(ifc.ic_stall_req_o), 32'd1);
        wait_resp(NONE, NONE);
        chk("conf_inst", ifc.ic_inst_o, 32'h10A0);
        check_addrs("conf", 32'h110);
        cyc(1'b1, 32'h10, 1'b0, 1'b0); #2;
        chk("conf_remiss", 32'(ifc.ic_stall_req_o), 32'd1);
        wait_resp(NONE, NONE);
        chk("conf_reinst", ifc.ic_inst_o, 32'hA0);

        // Kill during refill
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        wait_resp(32'h24, NONE);
        chk("kill_valid", 32'(ifc.ic_inst_valid_o), 32'd0);
        cyc(1'b1, 32'h24, 1'b0, 1'b0); #2;
        chk("kill_hit_stall", 32'(ifc.ic_stall_req_o), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0); #2;
        chk("kill_hit_inst",  ifc.ic_inst_o, 32'h1A1);
        chk("kill_hit_valid", 32'(ifc.ic_inst_valid_o), 32'd1);

        // Flush during refill
        cyc(1'b1, 32'h30, 1'b0, 1'b0);
        wait_resp(NONE, 32'h34);
        chk("flush_valid", 32'(ifc.ic_inst_valid_o), 32'd1);
        chk("flush_inst",  ifc.ic_inst_o, 32'h2A0);
        cyc(1'b1, 32'h30, 1'b0, 1'b0); #2;
        chk("flush_remiss", 32'(ifc.ic_stall_req_o), 32'd1);
        wait_resp(NONE, NONE);

        // Reset after beat 2 of a refill
        addrq.delete();
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1'b0, 32'd0, 1'b0, 1'b0);
            if (addrq.size() == 3) seen = 1'b1;
        end
        chk("rstmid_timeout", 32'(seen), 32'd1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0; #2;
        chk("rstmid_memreq", 32'(ifc.ic_mem_req_o), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        addrq.delete();
        cyc(1'b1, 32'h40, 1'b0, 1'b0); #2;
        chk("rstmid_miss", 32'(ifc.ic_stall_req_o), 32'd1);
        wait_resp(NONE, NONE);
        check_addrs("rstmid", 32'h40);
        chk("rstmid_inst", ifc.ic_inst_o, 32'h3A0);

        // Random traffic over a small address window to force hits and conflicts
        rand_gap = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)),
                (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 39) == 0));
            if (addrq.size() > 64) addrq.delete();
        end
        repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
